// File: rtl/bp_fpga_host_nbf_rx.sv
// Purpose: assembles NBF packets from a UART byte stream (opcode, address LSB-first, data LSB-first).
// Latency: nbf_v_o rises the cycle after the final byte of a packet is sampled.
// Backpressure: the byte input is never stalled; a completed packet that finds the
//   one-entry output register full (and not draining this cycle) is dropped and flagged.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   rx_v_i, rx_i, rx_error_i  received byte strobe, byte, framing/parity error
//   nbf_o, nbf_v_o            assembled packet {data, addr, opcode} and its valid
//   nbf_ready_and_i           consumer ready
//   overflow_o, rx_error_o,   sticky status flags, cleared only by reset
//   timeout_o
module bp_fpga_host_nbf_rx #(
  parameter int nbf_addr_width_p = 40,
  parameter int nbf_data_width_p = 64,
  parameter int timeout_cycles_p = 1000000,
  localparam int nbf_width_lp    = 8 + nbf_addr_width_p + nbf_data_width_p,
  localparam int nbf_bytes_lp    = nbf_width_lp / 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    rx_v_i,
  input  logic [7:0]              rx_i,
  input  logic                    rx_error_i,
  output logic [nbf_width_lp-1:0] nbf_o,
  output logic                    nbf_v_o,
  input  logic                    nbf_ready_and_i,
  output logic                    overflow_o,
  output logic                    rx_error_o,
  output logic                    timeout_o
);

  localparam int cnt_w_lp  = $clog2(nbf_bytes_lp);
  localparam int tcnt_w_lp = $clog2(timeout_cycles_p + 1);

  localparam logic [cnt_w_lp-1:0]  last_cnt_lp = cnt_w_lp'(nbf_bytes_lp - 1);
  localparam logic [tcnt_w_lp-1:0] tmo_last_lp = tcnt_w_lp'(timeout_cycles_p - 1);
  localparam logic [tcnt_w_lp-1:0] tmo_max_lp  = tcnt_w_lp'(timeout_cycles_p);

  typedef enum logic {e_idle, e_collect} state_e;

  state_e                state_r, state_n;
  logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
  logic [tcnt_w_lp-1:0]  tcnt_r, tcnt_n;

  // The final byte is never stored here; it is merged straight into the output register.
  logic [nbf_bytes_lp-2:0][7:0] buf_r;

  logic [nbf_width_lp-1:0] nbf_r;
  logic                    nbf_v_r;
  logic                    overflow_r, rx_error_r, timeout_r;

  logic store_en, complete, err_set, tmo_set, handshake;

  assign handshake = nbf_v_r & nbf_ready_and_i;

  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    tcnt_n   = tcnt_r;
    store_en = 1'b0;
    complete = 1'b0;
    err_set  = 1'b0;
    tmo_set  = 1'b0;
    unique case (state_r)
      e_idle: begin
        tcnt_n = '0;
        if (rx_v_i) begin
          if (rx_error_i) begin
            err_set = 1'b1;
          end else begin
            store_en = 1'b1;
            cnt_n    = cnt_w_lp'(1);
            state_n  = e_collect;
          end
        end
      end
      e_collect: begin
        if (rx_v_i) begin
          tcnt_n = '0;
          if (rx_error_i) begin
            err_set = 1'b1;
            cnt_n   = '0;
            state_n = e_idle;
          end else if (cnt_r == last_cnt_lp) begin
            complete = 1'b1;
            cnt_n    = '0;
            state_n  = e_idle;
          end else begin
            store_en = 1'b1;
            cnt_n    = cnt_r + cnt_w_lp'(1);
          end
        end else if (tcnt_r == tmo_last_lp) begin
          // A byte on this same cycle would have taken the branch above instead.
          tmo_set = 1'b1;
          tcnt_n  = '0;
          cnt_n   = '0;
          state_n = e_idle;
        end else if (tcnt_r != tmo_max_lp) begin
          tcnt_n = tcnt_r + tcnt_w_lp'(1);
        end
      end
      default: begin
        state_n = e_idle;
        cnt_n   = '0;
        tcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      cnt_r      <= '0;
      tcnt_r     <= '0;
      buf_r      <= '0;
      nbf_r      <= '0;
      nbf_v_r    <= 1'b0;
      overflow_r <= 1'b0;
      rx_error_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      tcnt_r  <= tcnt_n;

      if (store_en) begin
        for (int i = 0; i < nbf_bytes_lp - 1; i++) begin
          if (cnt_r == cnt_w_lp'(i)) buf_r[i] <= rx_i;
        end
      end

      // Output register: a completion may refill it on the same cycle it drains.
      if (complete && (!nbf_v_r || handshake)) begin
        nbf_r   <= {rx_i, buf_r};
        nbf_v_r <= 1'b1;
      end else begin
        if (complete) overflow_r <= 1'b1;
        if (handshake) nbf_v_r <= 1'b0;
      end

      if (err_set) rx_error_r <= 1'b1;
      if (tmo_set) timeout_r  <= 1'b1;
    end
  end

  assign nbf_o      = nbf_r;
  assign nbf_v_o    = nbf_v_r;
  assign overflow_o = overflow_r;
  assign rx_error_o = rx_error_r;
  assign timeout_o  = timeout_r;

endmodule

// File: tb/tb_bp_fpga_host_nbf_rx.sv
// Purpose: scoreboard bench for bp_fpga_host_nbf_rx with directed packets.
// Latency: expects nbf_v_o one cycle after the last byte of each packet.
// Backpressure: drives nbf_ready_and_i low to exercise holding and overflow.
module tb_bp_fpga_host_nbf_rx;

  localparam int W = 112;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_v;
  logic [7:0]   rx;
  logic         rx_error;
  logic [W-1:0] nbf;
  logic         nbf_v;
  logic         nbf_ready;
  logic         overflow, rx_error_flag, timeout;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  bp_fpga_host_nbf_rx #(
    .nbf_addr_width_p(40),
    .nbf_data_width_p(64),
    .timeout_cycles_p(16)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .rx_v_i         (rx_v),
    .rx_i           (rx),
    .rx_error_i     (rx_error),
    .nbf_o          (nbf),
    .nbf_v_o        (nbf_v),
    .nbf_ready_and_i(nbf_ready),
    .overflow_o     (overflow),
    .rx_error_o     (rx_error_flag),
    .timeout_o      (timeout)
  );

  always #5 clk = ~clk;

  // Monitor: pops the scoreboard on every handshake, and checks that a stalled
  // packet holds its value across the following edge.
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_dat;
  always @(negedge clk) begin
    if (stall_prev) begin
      checks++;
      if (!nbf_v || nbf !== stall_dat) begin
        errors++;
        $display("FAIL hold: got v=%0b %h required v=1 %h", nbf_v, nbf, stall_dat);
      end
    end
    stall_prev <= nbf_v && !nbf_ready && !reset;
    stall_dat  <= nbf;
    if (!reset && nbf_v && nbf_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pkt: got %h required none", nbf);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (nbf !== e) begin
          errors++;
          $display("FAIL pkt: got %h required %h", nbf, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Caller sits at posedge+1; the byte is sampled at the next edge.
  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_v = 1'b1; rx = b; rx_error = err;
    @(posedge clk); #1;
    rx_v = 1'b0; rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Bytes [first, last] of packet p in wire order (byte i = p[8i+:8]).
  task automatic send_range(input logic [W-1:0] p, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(p[8*i +: 8], 1'b0);
  endtask

  logic [7:0]   basic_bytes [14] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h88,
                                     8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [W-1:0] pa, pb, pc, pd, pe, pf, pg, ph;

  initial begin
    pa = {64'hA1A2A3A4A5A6A7A8, 40'h00DEADBEEF, 8'h01};
    pb = {64'hB0B1B2B3B4B5B6B7, 40'h1234567890, 8'hFF};
    pc = {64'h0123456789ABCDEF, 40'hFEDCBA9876, 8'h03};
    pd = {64'hCAFEF00D12345678, 40'h0000001000, 8'h00};
    pe = {64'h8877665544332211, 40'hAABBCCDDEE, 8'h7E};
    pf = {64'h5555AAAA5555AAAA, 40'h0F0F0F0F0F, 8'h10};
    pg = {64'h9999888877776666, 40'h1111111111, 8'h20};
    ph = {64'hDEADBEEFCAFEBABE, 40'h8000000001, 8'h81};

    reset = 1'b1; rx_v = 1'b0; rx = '0; rx_error = 1'b0; nbf_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);

    // Reset state
    chk("rst_v",   W'(nbf_v), W'(0));
    chk("rst_nbf", nbf, '0);
    chk("rst_flags", W'({overflow, rx_error_flag, timeout}), W'(0));

    // Basic packet with ready high
    exp_q.push_back({64'h1122334455667788, 40'h0080000000, 8'h02});
    for (int i = 0; i < 14; i++) send_byte(basic_bytes[i], 1'b0);
    chk("basic_v_rise", W'(nbf_v), W'(1));
    idle(1);
    chk("basic_v_fall", W'(nbf_v), W'(0));

    // Completion of B on the same edge that A handshakes
    nbf_ready = 1'b0;
    exp_q.push_back(pa);
    send_range(pa, 0, 13);
    exp_q.push_back(pb);
    send_range(pb, 0, 12);
    nbf_ready = 1'b1;
    send_byte(pb[8*13 +: 8], 1'b0);
    chk("simul_v",   W'(nbf_v), W'(1));
    chk("simul_nbf", nbf, pb);
    chk("simul_ovf", W'(overflow), W'(0));
    idle(1);
    chk("simul_v_fall", W'(nbf_v), W'(0));

    // Error byte discards a partial packet; the next packet is aligned
    send_range(pf, 0, 4);
    send_byte(8'h5A, 1'b1);
    chk("rxerr_flag", W'(rx_error_flag), W'(1));
    chk("rxerr_v",    W'(nbf_v), W'(0));
    exp_q.push_back(pc);
    send_range(pc, 0, 13);
    idle(2);

    // Byte arriving on the last idle cycle before timeout keeps the packet alive
    exp_q.push_back(pe);
    send_range(pe, 0, 2);
    idle(15);
    send_range(pe, 3, 13);
    chk("no_tmo_flag", W'(timeout), W'(0));
    idle(2);

    // Timeout discards a 3-byte partial; next byte is an opcode
    send_range(pg, 0, 2);
    idle(16);
    chk("tmo_flag", W'(timeout), W'(1));
    exp_q.push_back(pd);
    send_range(pd, 0, 13);
    idle(2);

    // Overflow: A2 held, B2 dropped
    chk("pre_ovf", W'(overflow), W'(0));
    nbf_ready = 1'b0;
    exp_q.push_back(pa);
    send_range(pa, 0, 13);
    chk("ovf_hold_v", W'(nbf_v), W'(1));
    send_range(pb, 0, 13);
    chk("ovf_flag", W'(overflow), W'(1));
    chk("ovf_nbf",  nbf, pa);
    nbf_ready = 1'b1;
    idle(3);
    chk("ovf_b_gone", W'(nbf_v), W'(0));

    // Reset mid-packet with a packet held
    nbf_ready = 1'b0;
    send_range(pf, 0, 13);
    send_range(pg, 0, 6);
    chk("prerst_v", W'(nbf_v), W'(1));
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midrst_v",     W'(nbf_v), W'(0));
    chk("midrst_nbf",   nbf, '0);
    chk("midrst_flags", W'({overflow, rx_error_flag, timeout}), W'(0));
    nbf_ready = 1'b1;
    exp_q.push_back(ph);
    send_range(ph, 0, 13);
    idle(3);

    chk("queue_empty", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
